// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle control FSM: state codes, opcodes,
// ALU operation codes and datapath mux encodings.
package multicycle_control_pkg;

    localparam int OPW  = 4;
    localparam int ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        S_RST    = 4'h0,
        S_FETCH  = 4'h1,
        S_DECODE = 4'h2,
        S_EXEC   = 4'h3,
        S_R_WB   = 4'h4,
        S_MEM_RD = 4'h5,
        S_MEM_WB = 4'h6,
        S_MEM_WR = 4'h7,
        S_BRANCH = 4'h8,
        S_JUMP   = 4'h9,
        S_HALT   = 4'hF
    } state_t;

    localparam logic [OPW-1:0] OP_ADD  = 4'h0;
    localparam logic [OPW-1:0] OP_SUB  = 4'h1;
    localparam logic [OPW-1:0] OP_AND  = 4'h2;
    localparam logic [OPW-1:0] OP_OR   = 4'h3;
    localparam logic [OPW-1:0] OP_SLT  = 4'h4;
    localparam logic [OPW-1:0] OP_INC  = 4'h5;
    localparam logic [OPW-1:0] OP_LW   = 4'h6;
    localparam logic [OPW-1:0] OP_SW   = 4'h7;
    localparam logic [OPW-1:0] OP_BEQ  = 4'h8;
    localparam logic [OPW-1:0] OP_BNE  = 4'h9;
    localparam logic [OPW-1:0] OP_J    = 4'hA;
    localparam logic [OPW-1:0] OP_HALT = 4'hF;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;

    // mux4 feeding the ALU's first operand
    localparam logic [1:0] SRCA_A   = 2'd0;
    localparam logic [1:0] SRCA_B   = 2'd1;
    localparam logic [1:0] SRCA_C   = 2'd2;
    localparam logic [1:0] SRCA_ONE = 2'd3;

    // mux3 feeding the ALU's second operand
    localparam logic [1:0] SRCB_A   = 2'd0;
    localparam logic [1:0] SRCB_ONE = 2'd1;
    localparam logic [1:0] SRCB_C   = 2'd2;

    localparam logic [1:0] PC_INC = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;

    // Opcodes 0-5 all go through EXEC / R_WB.
    function automatic logic is_alu_op(input logic [OPW-1:0] op);
        return op <= OP_INC;
    endfunction

    function automatic logic is_legal(input logic [OPW-1:0] op);
        return (op <= OP_J) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/multicycle_control_alu_op_decode.sv
// Combinational opcode -> ALU control decode used while in EXEC and R_WB.
module alu_op_decode
    import multicycle_control_pkg::*;
(
    input  logic [OPW-1:0] opcode,
    output logic [3:0]     aluct1,
    output logic           flip,
    output logic [1:0]     alusrcb
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        aluct1  = ALU_AND;
        flip    = 1'b0;
        alusrcb = SRCB_A;
        case (opcode)
            OP_ADD: begin aluct1 = ALU_ADD; alusrcb = SRCB_C;   end
            OP_SUB: begin aluct1 = ALU_SUB; alusrcb = SRCB_C;   end
            OP_AND: begin aluct1 = ALU_AND; alusrcb = SRCB_C;   end
            OP_OR:  begin aluct1 = ALU_OR;  alusrcb = SRCB_C;   end
            // slt swaps the operands so the ALU computes C < A
            OP_SLT: begin aluct1 = ALU_SLT; alusrcb = SRCB_C; flip = 1'b1; end
            OP_INC: begin aluct1 = ALU_ADD; alusrcb = SRCB_ONE; end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 16-bit RegFile / reg16 / mux / alu datapath:
// fetch, decode, execute, memory and writeback sequencing.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic [OPW-1:0]  Opcode,
    input  logic            Zero,
    input  logic            MemReady,
    output logic            Write,
    output logic            RegWrite,
    output logic            WBSrc,
    output logic [1:0]      ALUsrcA,
    output logic [1:0]      ALUsrcB,
    output logic [3:0]      ALUct1,
    output logic            Flip,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            PCWrite,
    output logic [1:0]      PCSrc,
    output logic            Halted,
    output logic            Illegal,
    output logic [ST_W-1:0] StateDbg
);

    state_t     state, state_nxt;
    logic       illegal_q;
    logic       illegal_set;
    logic [3:0] dec_aluct1;
    logic       dec_flip;
    logic [1:0] dec_alusrcb;

    alu_op_decode u_alu_op_decode (
        .opcode  (Opcode),
        .aluct1  (dec_aluct1),
        .flip    (dec_flip),
        .alusrcb (dec_alusrcb)
    );

    assign illegal_set = (state == S_DECODE) && !is_legal(Opcode);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= S_RST;
            illegal_q <= 1'b0;
        end else begin
            // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
            state     <= state_nxt;
            illegal_q <= illegal_q | illegal_set;
        end
    end

    always_comb begin
        state_nxt = state;
        Write     = 1'b0;
        RegWrite  = 1'b0;
        WBSrc     = 1'b0;
        ALUsrcA   = SRCA_A;
        ALUsrcB   = SRCB_A;
        ALUct1    = ALU_AND;
        Flip      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCSrc     = PC_INC;
        Halted    = 1'b0;

        case (state)
            S_RST: state_nxt = S_FETCH;

            S_FETCH: begin
                MemRead = 1'b1;
                if (MemReady) begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    PCSrc     = PC_INC;
                    state_nxt = S_DECODE;
                end
            end

            S_DECODE: begin
                Write = 1'b1;
                if (is_alu_op(Opcode)) begin
                    state_nxt = S_EXEC;
                end else begin
                    case (Opcode)
                        OP_LW:   state_nxt = S_MEM_RD;
                        OP_SW:   state_nxt = S_MEM_WR;
                        OP_BEQ,
                        OP_BNE:  state_nxt = S_BRANCH;
                        OP_J:    state_nxt = S_JUMP;
                        OP_HALT: state_nxt = S_HALT;
                        default: state_nxt = S_FETCH;
                    endcase
                end
            end

            S_EXEC: begin
                ALUsrcA   = SRCA_A;
                ALUsrcB   = dec_alusrcb;
                ALUct1    = dec_aluct1;
                Flip      = dec_flip;
                state_nxt = S_R_WB;
            end

            // ALU selects stay as in EXEC so ALUOut is still valid at writeback
            S_R_WB: begin
                ALUsrcA   = SRCA_A;
                ALUsrcB   = dec_alusrcb;
                ALUct1    = dec_aluct1;
                Flip      = dec_flip;
                RegWrite  = 1'b1;
                WBSrc     = 1'b0;
                state_nxt = S_FETCH;
            end

            S_MEM_RD: begin
                MemRead = 1'b1;
                if (MemReady) state_nxt = S_MEM_WB;
            end

            S_MEM_WB: begin
                RegWrite  = 1'b1;
                WBSrc     = 1'b1;
                state_nxt = S_FETCH;
            end

            S_MEM_WR: begin
                MemWrite = 1'b1;
                if (MemReady) state_nxt = S_FETCH;
            end

            S_BRANCH: begin
                ALUsrcA   = SRCA_A;
                ALUsrcB   = SRCB_C;
                ALUct1    = ALU_SUB;
                Flip      = 1'b0;
                PCSrc     = PC_BR;
                PCWrite   = (Opcode == OP_BNE) ? !Zero : Zero;
                state_nxt = S_FETCH;
            end

            S_JUMP: begin
                PCWrite   = 1'b1;
                PCSrc     = PC_JMP;
                state_nxt = S_FETCH;
            end

            S_HALT: Halted = 1'b1;

            default: state_nxt = S_RST;
        endcase
    end

    assign Illegal  = illegal_q;
    assign StateDbg = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control plus hand-written
// sequences for asynchronous reset, ALU datapath results and HALT.
module tb_multicycle_control;

    typedef struct packed {
        logic       write;
        logic       regwrite;
        logic       wbsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [3:0] aluct1;
        logic       flip;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic [1:0] pcsrc;
        logic       halted;
        logic       illegal;
        logic [3:0] statedbg;
    } out_t;

    typedef struct {
        string      name;
        logic       rst_n;
        logic [3:0] op;
        logic       zero;
        logic       mr;
        out_t       exp;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [3:0] Opcode;
    logic       Zero, MemReady;
    logic       Write, RegWrite, WBSrc, Flip, MemRead, MemWrite, IRWrite, PCWrite, Halted, Illegal;
    logic [1:0] ALUsrcA, ALUsrcB, PCSrc;
    logic [3:0] ALUct1, StateDbg;
    out_t       act;

    int n_vec = 0;
    int n_err = 0;
    vec_t vecs[$];

    multicycle_control dut (
        .CLK(CLK), .RESET_N(RESET_N), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .Write(Write), .RegWrite(RegWrite), .WBSrc(WBSrc), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB),
        .ALUct1(ALUct1), .Flip(Flip), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .Halted(Halted), .Illegal(Illegal), .StateDbg(StateDbg)
    );

    always #5 CLK = ~CLK;

    assign act = {Write, RegWrite, WBSrc, ALUsrcA, ALUsrcB, ALUct1, Flip, MemRead,
                  MemWrite, IRWrite, PCWrite, PCSrc, Halted, Illegal, StateDbg};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive inputs just after the falling edge; outputs are sampled 2 ns later.
    task automatic step(input logic rst_n, input logic [3:0] op, input logic z, input logic mr);
        @(negedge CLK);
        RESET_N  = rst_n;
        Opcode   = op;
        Zero     = z;
        MemReady = mr;
        #2;
    endtask

    task automatic add_v(input string name, input logic rst_n, input logic [3:0] op,
                         input logic z, input logic mr, input out_t e);
        vec_t v;
        v.name = name; v.rst_n = rst_n; v.op = op; v.zero = z; v.mr = mr; v.exp = e;
        vecs.push_back(v);
    endtask

    function automatic out_t ill(input out_t e);
        out_t r = e;
        r.illegal = 1'b1;
        return r;
    endfunction

    function automatic out_t e_exec(input logic [1:0] b, input logic [3:0] ct, input logic fl);
        return '{alusrcb: b, aluct1: ct, flip: fl, statedbg: 4'h3, default: '0};
    endfunction

    function automatic out_t e_rwb(input logic [1:0] b, input logic [3:0] ct, input logic fl);
        return '{regwrite: 1'b1, alusrcb: b, aluct1: ct, flip: fl, statedbg: 4'h4, default: '0};
    endfunction

    function automatic out_t e_br(input logic pcw);
        return '{alusrcb: 2'd2, aluct1: 4'd6, pcsrc: 2'd1, pcwrite: pcw, statedbg: 4'h8, default: '0};
    endfunction

    // Reference model of the datapath mux3/mux4/alu around the controller.
    function automatic logic [15:0] alu_model(input logic [1:0] sa, input logic [1:0] sb,
                                              input logic [3:0] ct, input logic fl,
                                              input logic [15:0] a, input logic [15:0] b,
                                              input logic [15:0] c);
        logic [15:0] in1, in2, x, y;
        case (sa)
            2'd0: in1 = a;
            2'd1: in1 = b;
            2'd2: in1 = c;
            default: in1 = 16'd1;
        endcase
        case (sb)
            2'd0: in2 = a;
            2'd1: in2 = 16'd1;
            2'd2: in2 = c;
            default: in2 = 16'hxxxx;
        endcase
        x = fl ? in2 : in1;
        y = fl ? in1 : in2;
        case (ct)
            4'd0: return x & y;
            4'd1: return x | y;
            4'd2: return x + y;
            4'd6: return x - y;
            4'd7: return (x < y) ? 16'd1 : 16'd0;
            default: return 16'hdead;
        endcase
    endfunction

    // Runs one ALU instruction and checks the ALU result seen at R_WB.
    task automatic run_alu(input string name, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] c, input logic [15:0] exp);
        step(1'b1, op, 1'b0, 1'b1);
        check({name, "_fetch_state"}, {28'd0, StateDbg}, 32'h1);
        step(1'b1, op, 1'b0, 1'b1);
        step(1'b1, op, 1'b0, 1'b1);
        step(1'b1, op, 1'b0, 1'b1);
        check({name, "_rwb_regwrite"}, {31'd0, RegWrite}, 32'h1);
        check({name, "_aluout"}, {16'd0, alu_model(ALUsrcA, ALUsrcB, ALUct1, Flip, a, 16'd0, c)},
              {16'd0, exp});
    endtask

    initial begin
        out_t e0, ef, efw, ed, emr, emwb, emw, ej, eh;
        e0   = '0;
        ef   = '{memread: 1'b1, irwrite: 1'b1, pcwrite: 1'b1, statedbg: 4'h1, default: '0};
        efw  = '{memread: 1'b1, statedbg: 4'h1, default: '0};
        ed   = '{write: 1'b1, statedbg: 4'h2, default: '0};
        emr  = '{memread: 1'b1, statedbg: 4'h5, default: '0};
        emwb = '{regwrite: 1'b1, wbsrc: 1'b1, statedbg: 4'h6, default: '0};
        emw  = '{memwrite: 1'b1, statedbg: 4'h7, default: '0};
        ej   = '{pcwrite: 1'b1, pcsrc: 2'd2, statedbg: 4'h9, default: '0};
        eh   = '{halted: 1'b1, statedbg: 4'hF, default: '0};

        RESET_N = 1'b0; Opcode = 4'h0; Zero = 1'b0; MemReady = 1'b1;

        add_v("rst_hold",   0, 4'h0, 0, 1, e0);
        add_v("rst_rel",    1, 4'h0, 0, 1, e0);
        add_v("add_fetch",  1, 4'h0, 0, 1, ef);
        add_v("add_dec",    1, 4'h0, 0, 1, ed);
        add_v("add_exec",   1, 4'h0, 1, 1, e_exec(2'd2, 4'd2, 1'b0));
        add_v("add_wb",     1, 4'h0, 0, 1, e_rwb(2'd2, 4'd2, 1'b0));
        add_v("sub_fetch",  1, 4'h1, 0, 1, ef);
        add_v("sub_dec",    1, 4'h1, 0, 1, ed);
        add_v("sub_exec",   1, 4'h1, 0, 1, e_exec(2'd2, 4'd6, 1'b0));
        add_v("sub_wb",     1, 4'h1, 0, 1, e_rwb(2'd2, 4'd6, 1'b0));
        add_v("and_fetch",  1, 4'h2, 0, 1, ef);
        add_v("and_dec",    1, 4'h2, 0, 1, ed);
        add_v("and_exec",   1, 4'h2, 0, 1, e_exec(2'd2, 4'd0, 1'b0));
        add_v("and_wb",     1, 4'h2, 0, 1, e_rwb(2'd2, 4'd0, 1'b0));
        add_v("or_fetch",   1, 4'h3, 0, 1, ef);
        add_v("or_dec",     1, 4'h3, 0, 1, ed);
        add_v("or_exec",    1, 4'h3, 0, 1, e_exec(2'd2, 4'd1, 1'b0));
        add_v("or_wb",      1, 4'h3, 0, 1, e_rwb(2'd2, 4'd1, 1'b0));
        add_v("slt_fetch",  1, 4'h4, 0, 1, ef);
        add_v("slt_dec",    1, 4'h4, 0, 1, ed);
        add_v("slt_exec",   1, 4'h4, 0, 1, e_exec(2'd2, 4'd7, 1'b1));
        add_v("slt_wb",     1, 4'h4, 0, 1, e_rwb(2'd2, 4'd7, 1'b1));
        add_v("inc_fetch",  1, 4'h5, 0, 1, ef);
        add_v("inc_dec",    1, 4'h5, 0, 1, ed);
        add_v("inc_exec",   1, 4'h5, 0, 1, e_exec(2'd1, 4'd2, 1'b0));
        add_v("inc_wb",     1, 4'h5, 0, 1, e_rwb(2'd1, 4'd2, 1'b0));
        add_v("lw_fetch",   1, 4'h6, 1, 1, ef);
        add_v("lw_dec",     1, 4'h6, 1, 1, ed);
        add_v("lw_rd_w1",   1, 4'h6, 1, 0, emr);
        add_v("lw_rd_w2",   1, 4'h6, 1, 0, emr);
        add_v("lw_rd_w3",   1, 4'h6, 1, 0, emr);
        add_v("lw_rd_ok",   1, 4'h6, 1, 1, emr);
        add_v("lw_wb",      1, 4'h6, 1, 1, emwb);
        add_v("sw_fetch_w", 1, 4'h7, 0, 0, efw);
        add_v("sw_fetch",   1, 4'h7, 0, 1, ef);
        add_v("sw_dec",     1, 4'h7, 0, 1, ed);
        add_v("sw_wr_w",    1, 4'h7, 0, 0, emw);
        add_v("sw_wr_ok",   1, 4'h7, 0, 1, emw);
        add_v("beq1_fetch", 1, 4'h8, 1, 1, ef);
        add_v("beq1_dec",   1, 4'h8, 1, 1, ed);
        add_v("beq1_br",    1, 4'h8, 1, 1, e_br(1'b1));
        add_v("beq0_fetch", 1, 4'h8, 0, 1, ef);
        add_v("beq0_dec",   1, 4'h8, 0, 1, ed);
        add_v("beq0_br",    1, 4'h8, 0, 1, e_br(1'b0));
        add_v("bne1_fetch", 1, 4'h9, 1, 1, ef);
        add_v("bne1_dec",   1, 4'h9, 1, 1, ed);
        add_v("bne1_br",    1, 4'h9, 1, 1, e_br(1'b0));
        add_v("bne0_fetch", 1, 4'h9, 0, 1, ef);
        add_v("bne0_dec",   1, 4'h9, 0, 1, ed);
        add_v("bne0_br",    1, 4'h9, 0, 1, e_br(1'b1));
        add_v("j_fetch",    1, 4'hA, 0, 1, ef);
        add_v("j_dec",      1, 4'hA, 0, 1, ed);
        add_v("j_jump",     1, 4'hA, 0, 1, ej);
        add_v("ilc_fetch",  1, 4'hC, 0, 1, ef);
        add_v("ilc_dec",    1, 4'hC, 0, 1, ed);
        add_v("ile_fetch",  1, 4'hE, 0, 1, ill(ef));
        add_v("ile_dec",    1, 4'hE, 0, 1, ill(ed));
        add_v("ilj_fetch",  1, 4'hA, 0, 1, ill(ef));
        add_v("ilj_dec",    1, 4'hA, 0, 1, ill(ed));
        add_v("ilj_jump",   1, 4'hA, 0, 1, ill(ej));
        add_v("clr_rst",    0, 4'h0, 0, 1, e0);
        add_v("clr_rel",    1, 4'h0, 0, 1, e0);

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].op, vecs[i].zero, vecs[i].mr);
            check(vecs[i].name, {8'd0, act}, {8'd0, vecs[i].exp});
        end

        // Asynchronous reset in the middle of EXEC.
        step(1'b1, 4'h0, 1'b0, 1'b1);
        step(1'b1, 4'h0, 1'b0, 1'b1);
        step(1'b1, 4'h0, 1'b0, 1'b1);
        check("mid_exec_state", {28'd0, StateDbg}, 32'h3);
        #1 RESET_N = 1'b0;
        #1 check("async_rst_outs", {8'd0, act}, 32'h0);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        check("rst_no_regwrite", {8'd0, act}, 32'h0);
        step(1'b1, 4'h0, 1'b0, 1'b1);
        check("rst_rel_rst", {8'd0, act}, 32'h0);
        step(1'b1, 4'h0, 1'b0, 1'b1);
        check("rst_rel_fetch", {8'd0, act}, {8'd0, ef});

        // Completes the fetched add, then datapath-level results.
        step(1'b1, 4'h0, 1'b0, 1'b1);
        step(1'b1, 4'h0, 1'b0, 1'b1);
        step(1'b1, 4'h0, 1'b0, 1'b1);
        run_alu("add_1_3", 4'h0, 16'd1, 16'd3, 16'd4);
        run_alu("slt_1_3", 4'h4, 16'd1, 16'd3, 16'd0);
        run_alu("slt_3_1", 4'h4, 16'd3, 16'd1, 16'd1);
        run_alu("sub_3_1", 4'h1, 16'd3, 16'd1, 16'd2);
        run_alu("inc_7",   4'h5, 16'd7, 16'd9, 16'd8);
        run_alu("and_6_3", 4'h2, 16'd6, 16'd3, 16'd2);
        run_alu("or_6_3",  4'h3, 16'd6, 16'd3, 16'd7);

        // HALT holds forever regardless of inputs until a reset pulse.
        step(1'b1, 4'hF, 1'b0, 1'b1);
        step(1'b1, 4'hF, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 4'h0, k[0], 1'b1);
            check("halt_stuck", {8'd0, act}, {8'd0, eh});
        end
        step(1'b0, 4'h0, 1'b0, 1'b1);
        check("halt_rst", {8'd0, act}, 32'h0);
        step(1'b1, 4'h0, 1'b0, 1'b1);
        step(1'b1, 4'h0, 1'b0, 1'b1);
        check("halt_rel_fetch", {8'd0, act}, {8'd0, ef});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM that drives the 16-bit RegFile / reg16 A,B,C / mux3input16bit / mux4input16bit / alu datapath.
- Decodes a 4-bit opcode from the instruction register and sequences fetch, decode, execute, memory and writeback.
- Asserts every datapath select and enable.
- Consumes the alu Zero flag for branches and a MemReady handshake for memory stalls.

Parameters:
- OPW, 4, opcode width.
- ST_W, 4, state register width.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- Opcode  in  4  instruction opcode (IR[15:12]), stable from DECODE onward.
- Zero  in  1  alu Zero flag.
- MemReady  in  1  memory completes the current read/write this cycle.
- Write  out  1  latch enable for reg16 A, B, C.
- RegWrite  out  1  RegFile write enable.
- WBSrc  out  1  writeback data: 0 = ALUOut, 1 = memory data.
- ALUsrcA  out  2  mux4 select: 0=A, 1=B, 2=C, 3=const1.
- ALUsrcB  out  2  mux3 select: 0=A, 1=const1, 2=C.
- ALUct1  out  4  alu op: 0=and, 1=or, 2=add, 6=sub, 7=slt.
- Flip  out  1  alu operand swap.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- PCWrite  out  1  PC update.
- PCSrc  out  2  PC source: 0=PC+1, 1=branch target, 2=jump target.
- Halted  out  1  FSM parked in HALT.
- Illegal  out  1  sticky illegal-opcode flag.
- StateDbg  out  4  current state code.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. RESET_N=0 forces state RST and clears Illegal.
  - In RST all outputs are 0, including StateDbg=0.
  - RST -> FETCH on the first CLK edge after release.
- Default outputs: every output is 0 unless listed for the current state. All outputs are Moore (state only), except PCWrite in BRANCH, which also depends on Zero.
- Opcodes:
  - 0 add, 1 sub, 2 and, 3 or, 4 slt (R-type, operands A and C).
  - 5 inc (A+1).
  - 6 lw, 7 sw (address = B).
  - 8 beq, 9 bne (compare A and C).
  - A j.
  - F halt.
  - B-E illegal.
- FETCH: MemRead=1. While MemReady=0, hold state with IRWrite=0 and PCWrite=0.
  - When MemReady=1: IRWrite=1, PCWrite=1, PCSrc=0, then go to DECODE.
- DECODE: Write=1 (A,B,C capture RegFile outputs). Next state:
  - 0-5 -> EXEC
  - 6 -> MEM_RD
  - 7 -> MEM_WR
  - 8/9 -> BRANCH
  - A -> JUMP
  - F -> HALT
  - B-E -> FETCH, with Illegal set (stays set until reset).
- EXEC: ALUsrcA=0, then go to R_WB.
  - R-type: ALUsrcB=2.
  - inc: ALUsrcB=1.
  - ALUct1: add/inc=2, sub=6, and=0, or=1, slt=7.
  - Flip=1 only for slt (computes C<A), otherwise 0.
- R_WB: RegWrite=1, WBSrc=0, with EXEC's ALU selects held so ALUOut stays valid. Then go to FETCH.
- MEM_RD: MemRead=1. Hold until MemReady=1, then go to MEM_WB.
- MEM_WB: RegWrite=1, WBSrc=1, then go to FETCH.
- MEM_WR: MemWrite=1. Hold until MemReady=1, then go to FETCH.
- BRANCH: ALUsrcA=0, ALUsrcB=2, ALUct1=6, Flip=0, PCSrc=1.
  - PCWrite = Zero for beq, !Zero for bne.
  - Then go to FETCH.
- JUMP: PCWrite=1, PCSrc=2, then go to FETCH.
- HALT: Halted=1. All enables stay 0 forever until RESET_N=0.
- Latency with MemReady tied to 1:
  - R-type/inc: 4 cycles.
  - lw: 4 cycles.
  - sw, branch, j: 3 cycles.
  - Each MemReady=0 cycle adds one cycle.
- Reset mid-instruction: outputs drop to 0 immediately (asynchronous). No partial RegWrite or MemWrite is issued afterward.
- State codes: RST=0, FETCH=1, DECODE=2, EXEC=3, R_WB=4, MEM_RD=5, MEM_WB=6, MEM_WR=7, BRANCH=8, JUMP=9, HALT=F.

Decomposition:
- Shared include ctrl_defs.vh holds:
  - state codes
  - opcode constants
  - ALUct1 codes (AND=0, OR=1, ADD=2, SUB=6, SLT=7)
  - ALUsrcA/ALUsrcB/PCSrc encodings
- Sub-module alu_op_decode: combinational Opcode -> {ALUct1, Flip, ALUsrcB}, instantiated once and used in EXEC/R_WB.

Test Plan:
- Reset: RESET_N=0 mid-EXEC -> all outputs 0 and StateDbg=0 in the same cycle. After release, next edge gives FETCH with MemRead=1.
- add with MemReady=1, A=1, C=3 on the datapath: sequence FETCH, DECODE (Write=1), EXEC (ALUsrcA=0, ALUsrcB=2, ALUct1=2), R_WB (RegWrite=1, WBSrc=0) -> ALUOut=4.
- slt, A=1, C=3: EXEC drives ALUct1=7, Flip=1 -> ALUOut=0. Repeat with A=3, C=1 -> ALUOut=1.
- lw with MemReady low for 3 cycles in MEM_RD: MemRead held 4 cycles, then MEM_WB with RegWrite=1, WBSrc=1. Total 7 cycles.
- beq, A=C=2 -> BRANCH with PCWrite=1, PCSrc=1. bne with same operands -> PCWrite=0. Both return to FETCH.
- Opcode=C -> Illegal=1, back to FETCH, no RegWrite/MemWrite issued. Opcode=F -> Halted=1 and stuck until RESET_N pulse, which clears Illegal and Halted.
